// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous SRAM port between instruction fetch and data memory
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   if_req/if_addr -> if_gnt         fetch read request and same-cycle grant
//   if_rvalid/if_rdata               fetch read response, one cycle after grant
//   mem_req/wen/addr/wdata -> mem_gnt data request (wen==0 is a read) and grant
//   mem_rvalid/mem_rdata             data read response, one cycle after grant
//   sram_en/wen/addr/wdata           SRAM command driven by the grant winner
//   sram_rdata                       SRAM read data, valid the cycle after a read
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic [3:0]        mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_MEM} tag_e;

    tag_e       rsp_tag_q, rsp_tag_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       if_win;

    always_comb begin
        // fetch wins when alone, or once data has used up its consecutive-grant allowance
        if_win       = if_req && (!mem_req || starve_cnt_q >= 4'(STARVE_MAX));
        if_gnt       = !rst && if_win;
        mem_gnt      = !rst && mem_req && !if_win;
        starve_cnt_d = (mem_gnt && if_req) ?
                       ((starve_cnt_q >= 4'(STARVE_MAX)) ? 4'(STARVE_MAX) : starve_cnt_q + 4'd1) : 4'd0;
        sram_en      = if_gnt || mem_gnt;
        sram_addr    = if_gnt ? if_addr : (mem_gnt ? mem_addr : '0);
        sram_wen     = mem_gnt ? mem_wen : 4'd0;
        sram_wdata   = mem_gnt ? mem_wdata : '0;
        rsp_tag_d    = if_gnt ? TAG_IF : ((mem_gnt && mem_wen == 4'd0) ? TAG_MEM : TAG_NONE);
        // a read granted just before reset must not surface while reset is high
        if_rvalid    = !rst && rsp_tag_q == TAG_IF;
        mem_rvalid   = !rst && rsp_tag_q == TAG_MEM;
        if_rdata     = if_rvalid ? sram_rdata : '0;
        mem_rdata    = mem_rvalid ? sram_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_tag_q    <= TAG_NONE;
            starve_cnt_q <= 4'd0;
        end else begin
            rsp_tag_q    <= rsp_tag_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: randomized scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;
    localparam int SMAX = 4;

    typedef struct {
        int          cyc;
        logic        rst;
        logic        ig;
        logic        mg;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  st;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        is_if;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wen = '0;
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, sram_en;
    logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
    logic [3:0]  sram_wen;
    logic [31:0] sram_rdata = '0;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    exp_t gq[$];
    rsp_t rq[$];

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h3C1D_8000 : a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [3:0] w, logic [31:0] d);
        for (int b = 0; b < 4; b++) if (w[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    // SRAM environment model, driven purely from the DUT's sram_* pins
    logic [31:0] smem [logic [31:0]];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen == 4'd0) sram_rdata <= smem.exists(sram_addr) ? smem[sram_addr] : init_word(sram_addr);
            else smem[sram_addr] = merge(smem.exists(sram_addr) ? smem[sram_addr] : init_word(sram_addr), sram_wen, sram_wdata);
        end
    end

    // reference memory contents as the specification says they should evolve
    logic [31:0] ref_mem [logic [31:0]];
    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // requester intents
    logic        if_on = 0, mem_on = 0;
    logic [31:0] if_a = 0, mem_a = 0, mem_d = 0;
    logic [3:0]  mem_w = 0;
    int          waited = 0;

    task automatic step(input logic r);
        exp_t e;
        rsp_t p;
        logic ig, mg;
        rst = r;
        if_req = if_on; if_addr = if_a;
        mem_req = mem_on; mem_wen = mem_w; mem_addr = mem_a; mem_wdata = mem_d;
        // a response due in a reset cycle is suppressed
        if (r && rq.size() > 0 && rq[$].cyc == cyc) void'(rq.pop_back());
        ig = !r && if_on && (!mem_on || waited >= SMAX);
        mg = !r && mem_on && !ig;
        e.cyc = cyc; e.rst = r; e.ig = ig; e.mg = mg; e.en = ig | mg;
        e.addr = ig ? if_a : (mg ? mem_a : 32'd0);
        e.wen = mg ? mem_w : 4'd0;
        e.wd = mg ? mem_d : 32'd0;
        e.st = 4'(waited);
        gq.push_back(e);
        if (ig) begin
            p.cyc = cyc + 1; p.is_if = 1'b1; p.data = ref_rd(if_a);
            rq.push_back(p);
        end
        if (mg && mem_w == 4'd0) begin
            p.cyc = cyc + 1; p.is_if = 1'b0; p.data = ref_rd(mem_a);
            rq.push_back(p);
        end
        if (mg && mem_w != 4'd0) ref_mem[mem_a] = merge(ref_rd(mem_a), mem_w, mem_d);
        waited = (mg && if_on) ? waited + 1 : 0;
        if (ig) if_on = 0;
        if (mg) mem_on = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic new_fetch(input logic [31:0] a);
        if_on = 1; if_a = a;
    endtask

    task automatic new_mem(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        mem_on = 1; mem_w = w; mem_a = a; mem_d = d;
    endtask

    // monitor: compares the DUT against queued expectations every cycle
    always @(negedge clk) begin : mon
        exp_t        e;
        rsp_t        p;
        logic        due;
        logic [65:0] act_r, exp_r;
        if (gq.size() > 0) begin
            e = gq.pop_front();
            vectors++;
            if (e.cyc != cyc || {if_gnt, mem_gnt, sram_en, sram_wen, sram_addr, sram_wdata} !=
                {e.ig, e.mg, e.en, e.wen, e.addr, e.wd}) begin
                miscompares++;
                $display("FAIL grant_drive cyc=%0d rst=%0d got ig=%0d mg=%0d en=%0d wen=%h addr=%h wd=%h exp ig=%0d mg=%0d en=%0d wen=%h addr=%h wd=%h",
                         cyc, e.rst, if_gnt, mem_gnt, sram_en, sram_wen, sram_addr, sram_wdata,
                         e.ig, e.mg, e.en, e.wen, e.addr, e.wd);
            end
            vectors++;
            if (dut.starve_cnt_q !== e.st) begin
                miscompares++;
                $display("FAIL starve_cnt cyc=%0d got %0d exp %0d", cyc, dut.starve_cnt_q, e.st);
            end
            due = rq.size() > 0 && rq[0].cyc == cyc;
            p.cyc = 0; p.is_if = 0; p.data = 0;
            if (due) p = rq.pop_front();
            exp_r = due ? {p.is_if, p.is_if ? p.data : 32'd0, !p.is_if, p.is_if ? 32'd0 : p.data} : 66'd0;
            act_r = {if_rvalid, if_rdata, mem_rvalid, mem_rdata};
            vectors++;
            if (act_r !== exp_r) begin
                miscompares++;
                $display("FAIL response cyc=%0d got ifv=%0d ifd=%h memv=%0d memd=%h exp ifv=%0d ifd=%h memv=%0d memd=%h",
                         cyc, act_r[65], act_r[64:33], act_r[32], act_r[31:0],
                         exp_r[65], exp_r[64:33], exp_r[32], exp_r[31:0]);
            end
        end
    end

    initial begin
        int pi, pm;
        @(posedge clk);
        #1;
        // reset held with both requesters active, then mem must win first
        new_fetch(32'h0000_0010);
        new_mem(4'd0, 32'h0000_0008, 32'd0);
        repeat (3) step(1);
        step(0);
        step(0);
        // single fetch from the boot vector
        new_fetch(32'hBFC0_0000);
        step(0);
        step(0);
        // starvation: both sides continuously requesting
        for (int i = 0; i < 16; i++) begin
            if (!if_on) new_fetch(32'h0000_0200 + 32'(i * 4));
            if (!mem_on) new_mem(4'd0, 32'(($urandom_range(0, 15)) << 2), 32'd0);
            step(0);
        end
        while (if_on || mem_on) step(0);
        step(0);
        // store, load of the same word, then fetch
        new_mem(4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
        step(0);
        new_mem(4'h0, 32'h0000_0100, 32'd0);
        step(0);
        new_fetch(32'h0000_0040);
        step(0);
        step(0);
        // reset arriving the cycle after a fetch grant
        new_fetch(32'h0000_0044);
        step(0);
        step(1);
        step(0);
        step(0);
        // idle
        repeat (10) step(0);
        // random traffic with varying pressure and occasional reset
        for (int blk = 0; blk < 15; blk++) begin
            pi = $urandom_range(10, 100);
            pm = $urandom_range(10, 100);
            for (int i = 0; i < 200; i++) begin
                if (!if_on && $urandom_range(1, 100) <= pi) new_fetch(32'(($urandom_range(0, 63)) << 2));
                if (!mem_on && $urandom_range(1, 100) <= pm)
                    new_mem($urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)),
                            32'(($urandom_range(0, 31)) << 2), $urandom);
                step($urandom_range(0, 99) == 0);
            end
        end
        while (if_on || mem_on) step(0);
        step(0);
        step(0);
        vectors++;
        if (rq.size() != 0) begin
            miscompares++;
            $display("FAIL rsp_drain got %0d pending responses exp 0", rq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares a single synchronous SRAM port between the instruction-fetch requester and the data-memory requester of the MIPS core, for configurations where instruction and data space sit in one physical SRAM. Grants one access per cycle, with data priority and a starvation limit that guarantees fetch progress. It tracks the one outstanding read and steers the returned word to its owner one cycle later. It sits between the `mips` core's fetch/memory stages and the top-level `*_sram_*` pins.

## Interface
- `ADDR_W`, 32, address width of all ports
- `DATA_W`, 32, data width of all ports
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch is waiting; range 1..15
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch read request; held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched word
- `mem_req`  in  1  data request; held until `mem_gnt`
- `mem_wen`  in  4  byte write enables; 0 = read
- `mem_addr`  in  ADDR_W  data address
- `mem_wdata`  in  DATA_W  store data
- `mem_gnt`  out  1  data request accepted this cycle
- `mem_rvalid`  out  1  `mem_rdata` valid (read responses only)
- `mem_rdata`  out  DATA_W  loaded word
- `sram_en`  out  1  SRAM access enable
- `sram_wen`  out  4  SRAM byte write enables
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_wdata`  out  DATA_W  SRAM write data
- `sram_rdata`  in  DATA_W  SRAM read data, valid the cycle after an enabled read

## Operation
**Arbitration**
- Combinational, same cycle.
- Only `mem_req`: grant mem.
- Only `if_req`: grant fetch.
- Both requesting, `starve_cnt < STARVE_MAX`: grant mem.
- Both requesting, `starve_cnt == STARVE_MAX`: grant fetch.
- At most one of `if_gnt`/`mem_gnt` is high in any cycle.

**Starvation counter** (`starve_cnt`, 4 bits, saturating)
- Mem granted while `if_req` is high: +1, saturating at `STARVE_MAX`.
- Fetch granted, or `if_req` low: cleared to 0.

**SRAM drive**
- On a grant, `sram_en`=1 and `sram_addr` comes from the winner.
- Mem winner: `sram_wen`=`mem_wen`, `sram_wdata`=`mem_wdata`.
- Fetch winner: `sram_wen`=0, `sram_wdata`=0.
- No grant: all `sram_*` outputs 0.

**Response tracking**
- Registered tag `rsp_tag` ∈ {NONE, IF, MEM}.
- Fetch grant → next tag IF.
- Mem grant with `mem_wen`==0 → next tag MEM.
- Mem write, or no grant → next tag NONE.
- Writes complete at grant and produce no response.

**Response outputs**
- `if_rvalid` = (tag==IF); `mem_rvalid` = (tag==MEM).
- The owner's rdata = `sram_rdata`; the non-owner's rdata = 0.

## Timing
- Reset values:
  - All outputs 0 while `rst` is high.
  - `starve_cnt`=0, `rsp_tag`=NONE.
  - Grants are forced 0 during `rst`.
- Reset mid-operation: a read granted in the cycle before `rst` rises produces no `rvalid` in the cycle `rst` is high. The first cycle after `rst` falls has no `rvalid`.
- Grant latency: 0 cycles (same cycle as request, when the requester wins).
- Read latency: `rvalid` exactly 1 cycle after grant.
- Throughput: one grant per cycle. Back-to-back reads, including alternating owners, each get their response in order, with no bubble.
- Handshake:
  - Requesters hold `req`, `addr`, `wen`, `wdata` stable until their grant.
  - A requester may drop `req` only after its grant.
  - There is no response back-pressure; the owner must accept `rdata` in its `rvalid` cycle.
- Read after write to the same address in consecutive cycles returns the new data; this relies on SRAM write-then-read ordering, and no forwarding is done here.
- Worst-case fetch wait with continuous data traffic: `STARVE_MAX` cycles, then a fetch grant.

## Test plan
- **Reset:** hold `rst` 3 cycles with both requests high → all outputs 0. First cycle after release: `mem_gnt`=1, `if_gnt`=0, no `rvalid`.
- **Single fetch:** `if_req`, `if_addr`=0xBFC00000, SRAM returns 0x3C1D8000 → `if_gnt` same cycle. Next cycle `if_rvalid`=1, `if_rdata`=0x3C1D8000, `mem_rvalid`=0.
- **Starvation (`STARVE_MAX`=4):** both requests held continuously → grants M,M,M,M,F,M,M,M,M,F… Check that `starve_cnt` clears after each F.
- **Mixed stream:** mem store (`wen`=0xF, addr 0x100, data 0xDEADBEEF), then mem load of 0x100, then fetch, on consecutive cycles → store gives no `rvalid`. Load gives `mem_rvalid` with 0xDEADBEEF. Fetch gives `if_rvalid` the following cycle.
- **Reset mid-read:** fetch granted at cycle N, `rst` high at N+1 → `if_rvalid`=0 at N+1 and N+2, and `starve_cnt`=0.
- **Idle:** no requests for 10 cycles → `sram_en`=0, both `rvalid` low, `starve_cnt` stays 0.
